// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch sequencer: run/step/stall/halt-drain control
//
// Purpose:
//   Owns the fetch enable, the one-hot PC redirect selects and the
//   post-redirect NOP squash. Sequences run, single-step, stall and
//   halt-drain for the pipeline. Counts enabled cycles and fetched
//   (non-squashed) instructions for debug readout.
//
// Ports:
//   i_clock        system clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_run          pulse, IDLE -> RUN
//   i_step         pulse, IDLE -> STEP (one fetch slot)
//   i_clear        pulse, DONE -> IDLE, zeroes counters
//   i_stall        hazard stall, suppresses fetch this cycle
//   i_halt_instr   HALT decoded in the instruction just fetched
//   i_branch       branch-taken request
//   i_jump_inm     J/JAL request
//   i_jump_rs      JR/JALR request
//   o_valid        fetch stage enable
//   o_pipe_enable  enable for stages downstream of fetch
//   o_branch       gated branch select
//   o_jump_inm     gated immediate-jump select
//   o_jump_rs      gated register-jump select
//   o_nop_reg      fetch issues a NOP instead of memory data
//   o_state        FSM state code
//   o_done         high in DONE
//   o_err          sticky, multiple redirects in one accepted cycle
//   o_cycle_count  cycles with o_pipe_enable=1
//   o_instr_count  cycles with o_valid=1 and o_nop_reg=0

module fetch_controller #(
  parameter int NB_CNT       = 32,
  parameter int NOP_SLOTS    = 1,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_run,
  input  logic              i_step,
  input  logic              i_clear,
  input  logic              i_stall,
  input  logic              i_halt_instr,
  input  logic              i_branch,
  input  logic              i_jump_inm,
  input  logic              i_jump_rs,
  output logic              o_valid,
  output logic              o_pipe_enable,
  output logic              o_branch,
  output logic              o_jump_inm,
  output logic              o_jump_rs,
  output logic              o_nop_reg,
  output logic [2:0]        o_state,
  output logic              o_done,
  output logic              o_err,
  output logic [NB_CNT-1:0] o_cycle_count,
  output logic [NB_CNT-1:0] o_instr_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [2:0]        NOP_INIT   = 3'(NOP_SLOTS);
  localparam logic [3:0]        DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  localparam logic [NB_CNT-1:0] CNT_ONE    = NB_CNT'(1);

  state_t      state;
  state_t      state_next;
  logic [2:0]  nop_cnt;
  logic [3:0]  drain_cnt;
  logic        pipe_en;
  logic        err;
  logic        accept;
  logic        take;
  logic        halt_accept;
  logic        redirect_any;
  logic        redirect_multi;
  logic        fetching;

  // Fetch runs only in RUN/STEP and only when decode is not stalling.
  assign fetching    = (state == RUN || state == STEP) && !i_stall;
  assign o_valid     = fetching;
  assign o_nop_reg   = (nop_cnt != 3'd0);

  // An accept cycle is a real (non-squashed) fetch; requests are only
  // honoured here, and a HALT in the same slot drops any redirect.
  assign accept      = fetching && !o_nop_reg;
  assign halt_accept = accept && i_halt_instr;
  assign take        = accept && !i_halt_instr;

  assign redirect_any   = i_jump_rs || i_jump_inm || i_branch;
  assign redirect_multi = (i_jump_rs && i_jump_inm) || (i_jump_rs && i_branch) ||
                          (i_jump_inm && i_branch);

  // One-hot select with jump_rs > jump_inm > branch priority.
  assign o_jump_rs  = take && i_jump_rs;
  assign o_jump_inm = take && !i_jump_rs && i_jump_inm;
  assign o_branch   = take && !i_jump_rs && !i_jump_inm && i_branch;

  assign o_pipe_enable = pipe_en;
  assign o_state       = state;
  assign o_done        = (state == DONE);
  assign o_err         = err;

  // State register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE: begin
        if (i_run) begin
          state_next = RUN;
        end else if (i_step) begin
          state_next = STEP;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        state_next = halt_accept ? DRAIN : RUN;
      end
      STEP: begin
        // The step slot is consumed once it issues, squashed or not.
        if (halt_accept) begin
          state_next = DRAIN;
        end else if (fetching) begin
          state_next = IDLE;
        end else begin
          state_next = STEP;
        end
      end
      DRAIN: begin
        state_next = (drain_cnt == DRAIN_LAST) ? DONE : DRAIN;
      end
      DONE: begin
        state_next = i_clear ? IDLE : DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Downstream enable is a flop that tracks the state it will be in,
  // so it lines up cycle-for-cycle with the state register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      pipe_en <= 1'b0;
    end else begin
      pipe_en <= (state_next == RUN) || (state_next == STEP) || (state_next == DRAIN);
    end
  end

  // Drain length counter
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      drain_cnt <= 4'd0;
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt + 4'd1;
    end else begin
      drain_cnt <= 4'd0;
    end
  end

  // Squash counter: loaded on an accepted redirect, decremented only on
  // slots that actually issue (stalled cycles keep the window open).
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      nop_cnt <= 3'd0;
    end else if (halt_accept) begin
      nop_cnt <= 3'd0;
    end else if (take && redirect_any) begin
      nop_cnt <= NOP_INIT;
    end else if (fetching && o_nop_reg) begin
      nop_cnt <= nop_cnt - 3'd1;
    end
  end

  // Sticky multiple-redirect error
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      err <= 1'b0;
    end else if (take && redirect_multi) begin
      err <= 1'b1;
    end
  end

  // Debug counters, free-wrapping
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_cycle_count <= '0;
      o_instr_count <= '0;
    end else if (state == DONE && i_clear) begin
      o_cycle_count <= '0;
      o_instr_count <= '0;
    end else begin
      if (pipe_en) begin
        o_cycle_count <= o_cycle_count + CNT_ONE;
      end
      if (accept) begin
        o_instr_count <= o_instr_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed self-checking bench for fetch_controller
module tb_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic        run, step, clear, stall, halt, br, jinm, jrs;
  logic        valid, pipe_en, o_br, o_jinm, o_jrs, nop, done, err;
  logic [2:0]  state;
  logic [31:0] cyc_cnt, ins_cnt;

  int n_checks = 0;
  int n_errors = 0;

  fetch_controller #(.NB_CNT(32), .NOP_SLOTS(1), .DRAIN_CYCLES(4)) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_run         (run),
    .i_step        (step),
    .i_clear       (clear),
    .i_stall       (stall),
    .i_halt_instr  (halt),
    .i_branch      (br),
    .i_jump_inm    (jinm),
    .i_jump_rs     (jrs),
    .o_valid       (valid),
    .o_pipe_enable (pipe_en),
    .o_branch      (o_br),
    .o_jump_inm    (o_jinm),
    .o_jump_rs     (o_jrs),
    .o_nop_reg     (nop),
    .o_state       (state),
    .o_done        (done),
    .o_err         (err),
    .o_cycle_count (cyc_cnt),
    .o_instr_count (ins_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " state"}, 32'(state), 32'd0);
    check({tag, " valid"}, 32'(valid), 32'd0);
    check({tag, " pipe"},  32'(pipe_en), 32'd0);
    check({tag, " nop"},   32'(nop), 32'd0);
    check({tag, " sel"},   32'({o_jrs, o_jinm, o_br}), 32'd0);
    check({tag, " done"},  32'(done), 32'd0);
    check({tag, " err"},   32'(err), 32'd0);
    check({tag, " cyc"},   cyc_cnt, 32'd0);
    check({tag, " ins"},   ins_cnt, 32'd0);
  endtask

  task automatic do_step(input bit stall_once, input string tag);
    step = 1'b1;
    tick();
    step = 1'b0;
    check({tag, " in_step"}, 32'(state), 32'd2);
    if (stall_once) begin
      stall = 1'b1;
      #1;
      check({tag, " stalled_valid"}, 32'(valid), 32'd0);
      tick();
      check({tag, " held_step"}, 32'(state), 32'd2);
      stall = 1'b0;
      #1;
    end
    check({tag, " step_valid"}, 32'(valid), 32'd1);
    tick();
    check({tag, " back_idle"}, 32'(state), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    {run, step, clear, stall, halt, br, jinm, jrs} = '0;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Free run for 10 cycles
    run = 1'b1;
    tick();
    run = 1'b0;
    check("run state", 32'(state), 32'd1);
    check("run valid", 32'(valid), 32'd1);
    check("run pipe",  32'(pipe_en), 32'd1);
    repeat (10) tick();
    check("run10 ins", ins_cnt, 32'd10);
    check("run10 cyc", cyc_cnt, 32'd10);
    check("run10 nop", 32'(nop), 32'd0);

    // Branch then one squash slot; request during squash is ignored
    br = 1'b1;
    #1;
    check("br sel", 32'({o_jrs, o_jinm, o_br}), 32'b001);
    tick();
    check("br squash", 32'(nop), 32'd1);
    #1;
    check("br in squash sel", 32'({o_jrs, o_jinm, o_br}), 32'b000);
    tick();
    br = 1'b0;
    check("br squash done", 32'(nop), 32'd0);
    check("br ins", ins_cnt, 32'd11);
    check("br cyc", cyc_cnt, 32'd12);

    // Stall holds the squash window open
    jinm = 1'b1;
    #1;
    check("jinm sel", 32'({o_jrs, o_jinm, o_br}), 32'b010);
    tick();
    jinm = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall valid", 32'(valid), 32'd0);
      check("stall nop", 32'(nop), 32'd1);
      tick();
    end
    stall = 1'b0;
    check("post stall nop", 32'(nop), 32'd1);
    check("stall cyc", cyc_cnt, 32'd16);
    check("stall ins", ins_cnt, 32'd12);
    tick();
    check("unstall nop clr", 32'(nop), 32'd0);
    check("unstall ins", ins_cnt, 32'd12);

    // All three requests: jump_rs wins, error set and sticky
    {jrs, jinm, br} = 3'b111;
    #1;
    check("multi sel", 32'({o_jrs, o_jinm, o_br}), 32'b100);
    tick();
    {jrs, jinm, br} = 3'b000;
    check("multi err", 32'(err), 32'd1);
    tick();
    check("multi err sticky", 32'(err), 32'd1);
    check("multi ins", ins_cnt, 32'd13);
    check("multi cyc", cyc_cnt, 32'd19);

    // Halt with branch: branch dropped, 4 drain cycles, then DONE
    halt = 1'b1;
    br = 1'b1;
    #1;
    check("halt br sel", 32'(o_br), 32'd0);
    tick();
    halt = 1'b0;
    br = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain state", 32'(state), 32'd3);
      check("drain valid", 32'(valid), 32'd0);
      check("drain pipe",  32'(pipe_en), 32'd1);
      check("drain nop",   32'(nop), 32'd0);
      tick();
    end
    run = 1'b0;
    check("done state", 32'(state), 32'd4);
    check("done flag", 32'(done), 32'd1);
    check("done pipe", 32'(pipe_en), 32'd0);
    check("done ins", ins_cnt, 32'd14);
    check("done cyc", cyc_cnt, 32'd24);
    tick();
    check("done hold", 32'(state), 32'd4);
    check("done hold cyc", cyc_cnt, 32'd24);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear state", 32'(state), 32'd0);
    check("clear done", 32'(done), 32'd0);
    check("clear cyc", cyc_cnt, 32'd0);
    check("clear ins", ins_cnt, 32'd0);
    check("clear err kept", 32'(err), 32'd1);

    // Three single steps, second one stalled
    do_step(1'b0, "step1");
    do_step(1'b1, "step2");
    do_step(1'b0, "step3");
    check("step ins", ins_cnt, 32'd3);
    check("step cyc", cyc_cnt, 32'd4);

    // Asynchronous reset in RUN, mid squash window
    run = 1'b1;
    tick();
    run = 1'b0;
    br = 1'b1;
    tick();
    br = 1'b0;
    check("pre reset nop", 32'(nop), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    tick();
    rst_n = 1'b1;
    tick();
    check("post reset idle", 32'(state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
